// File: rtl/bcd_countdown_timer.sv
// BCD SS.t countdown timer for the game round: load/start/pause control,
// digits for the 7-seg driver, low-time warning and a one-cycle expiry pulse.
module bcd_countdown_timer #(
    parameter int unsigned DEFAULT_TENS = 3,
    parameter int unsigned DEFAULT_ONES = 0,
    parameter int unsigned WARN_SEC     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_100ms_in,
    input  logic        load,
    input  logic [11:0] load_value,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  digit_tens,
    output logic [3:0]  digit_ones,
    output logic [3:0]  digit_tenths,
    output logic        running,
    output logic        warn,
    output logic        expired,
    output logic        load_err
);

    localparam int unsigned DW = 4;
    localparam logic [DW-1:0] BCD_MAX = DW'(9);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] tens_q, tens_d;
    logic [DW-1:0] ones_q, ones_d;
    logic [DW-1:0] tenths_q, tenths_d;
    logic          running_q, running_d;
    logic          warn_q, warn_d;
    logic          expired_q, expired_d;
    logic          load_err_q, load_err_d;

    logic          load_ok;
    logic          count_zero;
    logic [DW-1:0] dec_tens, dec_ones, dec_tenths;
    logic          dec_zero;

    assign load_ok = (load_value[11:8] <= BCD_MAX) &&
                     (load_value[7:4]  <= BCD_MAX) &&
                     (load_value[3:0]  <= BCD_MAX);

    assign count_zero = (tens_q == '0) && (ones_q == '0) && (tenths_q == '0);

    // BCD decrement with borrow chain; only used when the count is non-zero.
    always_comb begin
        dec_tens   = tens_q;
        dec_ones   = ones_q;
        dec_tenths = tenths_q;
        if (tenths_q != '0) begin
            dec_tenths = tenths_q - DW'(1);
        end else begin
            dec_tenths = BCD_MAX;
            if (ones_q != '0) begin
                dec_ones = ones_q - DW'(1);
            end else begin
                dec_ones = BCD_MAX;
                dec_tens = tens_q - DW'(1);
            end
        end
    end

    assign dec_zero = (dec_tens == '0) && (dec_ones == '0) && (dec_tenths == '0);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        tenths_d   = tenths_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (tick_100ms_in) begin
                    tens_d   = dec_tens;
                    ones_d   = dec_ones;
                    tenths_d = dec_tenths;
                    if (dec_zero) begin
                        state_d   = ST_DONE;
                        expired_d = 1'b1;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                // IDLE, PAUSED and DONE share load handling; a load request owns the cycle.
                if (load) begin
                    if (load_ok) begin
                        tens_d   = load_value[11:8];
                        ones_d   = load_value[7:4];
                        tenths_d = load_value[3:0];
                        state_d  = ST_IDLE;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (start && (state_q != ST_DONE) && !count_zero) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        running_d = (state_d == ST_RUN);
        warn_d    = (state_d == ST_RUN) && (tens_d == '0) && (ones_d < DW'(WARN_SEC));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tens_q     <= DW'(DEFAULT_TENS);
            ones_q     <= DW'(DEFAULT_ONES);
            tenths_q   <= '0;
            running_q  <= 1'b0;
            warn_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tenths_q   <= tenths_d;
            running_q  <= running_d;
            warn_q     <= warn_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign digit_tens   = tens_q;
    assign digit_ones   = ones_q;
    assign digit_tenths = tenths_q;
    assign running      = running_q;
    assign warn         = warn_q;
    assign expired      = expired_q;
    assign load_err     = load_err_q;

endmodule
